// File: rtl/mtx_fsk_tag_seq.sv
// mtx_fsk_tag_seq: FSK bit sequencer for the tag-chip transmit path.
// Latches a frame and its timing parameters, then sends the frame LSB-first
// as per-sample phase increments for the DDS. It also produces a hop clock
// for each bit and a hop reset before each frame.
module mtx_fsk_tag_seq #(
  parameter int PHASE_WIDTH   = 24,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7,
  parameter int NSIG_WIDTH    = 16,
  parameter int NREP_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [TX_BITS_WIDTH-1:0] tx_bits,
  input  logic [BIT_CNT_WIDTH:0]   ntx_bits,
  input  logic [NSIG_WIDTH-1:0]    nsig,
  input  logic [NREP_WIDTH-1:0]    nrep,
  input  logic [PHASE_WIDTH-1:0]   ph_inc0,
  input  logic [PHASE_WIDTH-1:0]   ph_inc1,
  output logic [PHASE_WIDTH-1:0]   ph_inc,
  output logic                     tx_valid,
  output logic                     hop_clk,
  output logic                     hop_rst,
  output logic                     busy,
  output logic                     done,
  output logic [BIT_CNT_WIDTH-1:0] bit_idx,
  output logic [NREP_WIDTH-1:0]    rep_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  localparam logic [BIT_CNT_WIDTH:0]   MAX_BITS  = (BIT_CNT_WIDTH+1)'(TX_BITS_WIDTH);
  localparam logic [BIT_CNT_WIDTH:0]   BITS_ONE  = (BIT_CNT_WIDTH+1)'(1);
  localparam logic [BIT_CNT_WIDTH:0]   BITS_ZERO = (BIT_CNT_WIDTH+1)'(0);
  localparam logic [BIT_CNT_WIDTH-1:0] IDX_ZERO  = {BIT_CNT_WIDTH{1'b0}};
  localparam logic [BIT_CNT_WIDTH-1:0] IDX_ONE   = BIT_CNT_WIDTH'(1);
  localparam logic [NSIG_WIDTH-1:0]    NSIG_MIN  = NSIG_WIDTH'(2);
  localparam logic [NSIG_WIDTH-1:0]    NSIG_ZERO = {NSIG_WIDTH{1'b0}};
  localparam logic [NSIG_WIDTH-1:0]    NSIG_ONE  = NSIG_WIDTH'(1);
  localparam logic [NREP_WIDTH-1:0]    REP_ZERO  = {NREP_WIDTH{1'b0}};
  localparam logic [NREP_WIDTH-1:0]    REP_MAX   = {NREP_WIDTH{1'b1}};
  localparam logic [PHASE_WIDTH-1:0]   PH_ZERO   = {PHASE_WIDTH{1'b0}};

  // Frame length is limited to the payload register width.
  function automatic logic [BIT_CNT_WIDTH:0] clamp_bits(input logic [BIT_CNT_WIDTH:0] n);
    if (n > MAX_BITS) return MAX_BITS;
    else              return n;
  endfunction

  // A bit needs at least two samples so the hop clock has a high and a low half.
  function automatic logic [NSIG_WIDTH-1:0] clamp_nsig(input logic [NSIG_WIDTH-1:0] n);
    if (n < NSIG_MIN) return NSIG_MIN;
    else              return n;
  endfunction

  state_t                     state_q, state_d;
  logic [TX_BITS_WIDTH-1:0]   bits_q, bits_d;
  logic [BIT_CNT_WIDTH:0]     nbits_q, nbits_d;
  logic [NSIG_WIDTH-1:0]      nsig_q, nsig_d;
  logic [NREP_WIDTH-1:0]      nrep_q, nrep_d;
  logic [PHASE_WIDTH-1:0]     ph0_q, ph0_d, ph1_q, ph1_d;
  logic [NSIG_WIDTH-1:0]      samp_q, samp_d;
  logic [BIT_CNT_WIDTH-1:0]   bit_idx_q, bit_idx_d;
  logic [NREP_WIDTH-1:0]      rep_cnt_q, rep_cnt_d;
  logic [PHASE_WIDTH-1:0]     ph_inc_q, ph_inc_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       hop_clk_q, hop_clk_d;
  logic                       hop_rst_q, hop_rst_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       last_sample_s;
  logic                       last_bit_s;
  logic [NREP_WIDTH:0]        rep_next_s;
  logic                       more_frames_s;
  logic [NREP_WIDTH-1:0]      rep_sat_s;

  // The frame ends on an index compare, so bit_idx never has to wrap.
  assign last_sample_s = (samp_q == (nsig_q - NSIG_ONE));
  assign last_bit_s    = ({1'b0, bit_idx_q} == (nbits_q - BITS_ONE));
  assign rep_next_s    = {1'b0, rep_cnt_q} + (NREP_WIDTH+1)'(1);
  assign more_frames_s = (nrep_q == REP_ZERO) || (rep_next_s < {1'b0, nrep_q});
  assign rep_sat_s     = (rep_cnt_q == REP_MAX) ? rep_cnt_q : rep_next_s[NREP_WIDTH-1:0];

  // Next-state logic: latching, sample/bit counting and frame sequencing.
  always_comb begin
    state_d   = state_q;
    bits_d    = bits_q;
    nbits_d   = nbits_q;
    nsig_d    = nsig_q;
    nrep_d    = nrep_q;
    ph0_d     = ph0_q;
    ph1_d     = ph1_q;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    rep_cnt_d = rep_cnt_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      samp_d    = NSIG_ZERO;
      bit_idx_d = IDX_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (ntx_bits != BITS_ZERO)) begin
            bits_d    = tx_bits;
            nbits_d   = clamp_bits(ntx_bits);
            nsig_d    = clamp_nsig(nsig);
            nrep_d    = nrep;
            ph0_d     = ph_inc0;
            ph1_d     = ph_inc1;
            rep_cnt_d = REP_ZERO;
            state_d   = ST_LOAD;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_LOAD: begin
          samp_d    = NSIG_ZERO;
          bit_idx_d = IDX_ZERO;
          state_d   = ST_TX;
        end
        ST_TX: begin
          if (last_sample_s) begin
            samp_d = NSIG_ZERO;
            if (last_bit_s) begin
              bit_idx_d = IDX_ZERO;
              rep_cnt_d = rep_sat_s;
              if (more_frames_s) begin
                state_d = ST_LOAD;
              end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              bit_idx_d = bit_idx_q + IDX_ONE;
            end
          end else begin
            samp_d = samp_q + NSIG_ONE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          samp_d    = NSIG_ZERO;
          bit_idx_d = IDX_ZERO;
        end
      endcase
    end
  end

  // Output decode from the state being entered, so outputs leave a flop.
  always_comb begin
    ph_inc_d   = PH_ZERO;
    tx_valid_d = 1'b0;
    hop_clk_d  = 1'b0;
    hop_rst_d  = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_LOAD: begin
        hop_rst_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_TX: begin
        busy_d     = 1'b1;
        tx_valid_d = 1'b1;
        hop_clk_d  = (samp_d < (nsig_q >> 1));
        ph_inc_d   = bits_q[bit_idx_d] ? ph1_q : ph0_q;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Latched frame parameters and the sample/bit/frame counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q    <= {TX_BITS_WIDTH{1'b0}};
      nbits_q   <= BITS_ZERO;
      nsig_q    <= NSIG_MIN;
      nrep_q    <= REP_ZERO;
      ph0_q     <= PH_ZERO;
      ph1_q     <= PH_ZERO;
      samp_q    <= NSIG_ZERO;
      bit_idx_q <= IDX_ZERO;
      rep_cnt_q <= REP_ZERO;
    end else begin
      bits_q    <= bits_d;
      nbits_q   <= nbits_d;
      nsig_q    <= nsig_d;
      nrep_q    <= nrep_d;
      ph0_q     <= ph0_d;
      ph1_q     <= ph1_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // Registered outputs to the DDS and host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_inc_q   <= PH_ZERO;
      tx_valid_q <= 1'b0;
      hop_clk_q  <= 1'b0;
      hop_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ph_inc_q   <= ph_inc_d;
      tx_valid_q <= tx_valid_d;
      hop_clk_q  <= hop_clk_d;
      hop_rst_q  <= hop_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ph_inc   = ph_inc_q;
  assign tx_valid = tx_valid_q;
  assign hop_clk  = hop_clk_q;
  assign hop_rst  = hop_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bit_idx  = bit_idx_q;
  assign rep_cnt  = rep_cnt_q;

endmodule

// File: tb/tb_mtx_fsk_tag_seq.sv
// Testbench for mtx_fsk_tag_seq: table of frame configurations with
// hand-derived summary counts, randomized frames, and hand-written
// abort/reset sequences. Every cycle is compared against a frame-level
// reference model.
`timescale 1ns/1ps
module tb_mtx_fsk_tag_seq;

  localparam int PW  = 24;
  localparam int TXW = 128;
  localparam int BCW = 7;
  localparam int NSW = 16;
  localparam int NRW = 8;
  localparam int CONT_FRAMES = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [TXW-1:0] tx_bits;
  logic [BCW:0]   ntx_bits;
  logic [NSW-1:0] nsig;
  logic [NRW-1:0] nrep;
  logic [PW-1:0]  ph_inc0;
  logic [PW-1:0]  ph_inc1;
  logic [PW-1:0]  ph_inc;
  logic           tx_valid;
  logic           hop_clk;
  logic           hop_rst;
  logic           busy;
  logic           done;
  logic [BCW-1:0] bit_idx;
  logic [NRW-1:0] rep_cnt;

  typedef struct packed {
    logic           busy;
    logic           done;
    logic           hop_rst;
    logic           tx_valid;
    logic           hop_clk;
    logic [BCW-1:0] bit_idx;
    logic [NRW-1:0] rep_cnt;
    logic [PW-1:0]  ph_inc;
  } obs_t;

  typedef struct {
    logic [TXW-1:0] bits;
    int             ntx;
    int             nsig;
    int             nrep;
    logic [PW-1:0]  ph0;
    logic [PW-1:0]  ph1;
  } cfg_t;

  typedef struct {
    cfg_t c;
    int   abort_at;
    int   e_busy;
    int   e_hr;
    int   e_txv;
    int   e_done;
    int   e_rep;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  int   model_rep = 0;
  int   cnt_busy, cnt_hr, cnt_txv, cnt_done;
  obs_t exp_q[$];
  vec_t vt[8];

  mtx_fsk_tag_seq #(
    .PHASE_WIDTH(PW), .TX_BITS_WIDTH(TXW), .BIT_CNT_WIDTH(BCW),
    .NSIG_WIDTH(NSW), .NREP_WIDTH(NRW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .tx_bits(tx_bits), .ntx_bits(ntx_bits), .nsig(nsig), .nrep(nrep),
    .ph_inc0(ph_inc0), .ph_inc1(ph_inc1), .ph_inc(ph_inc),
    .tx_valid(tx_valid), .hop_clk(hop_clk), .hop_rst(hop_rst),
    .busy(busy), .done(done), .bit_idx(bit_idx), .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o = {busy, done, hop_rst, tx_valid, hop_clk, bit_idx, rep_cnt, ph_inc};
    return o;
  endfunction

  function automatic cfg_t mk(input logic [TXW-1:0] b, input int n, input int ns,
                              input int nr, input logic [PW-1:0] p0, input logic [PW-1:0] p1);
    cfg_t c;
    c.bits = b; c.ntx = n; c.nsig = ns; c.nrep = nr; c.ph0 = p0; c.ph1 = p1;
    return c;
  endfunction

  task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual {busy,done,hop_rst,txv,hop_clk,idx,rep,ph}=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: lists the expected outputs of every cycle, frame by frame.
  task automatic build(input cfg_t c);
    int   n, ns, frames;
    obs_t e;
    exp_q.delete();
    if (c.ntx == 0) return;
    n      = (c.ntx > TXW) ? TXW : c.ntx;
    ns     = (c.nsig < 2) ? 2 : c.nsig;
    frames = (c.nrep == 0) ? CONT_FRAMES : c.nrep;
    for (int f = 0; f < frames; f++) begin
      e = '0; e.busy = 1'b1; e.hop_rst = 1'b1; e.rep_cnt = NRW'(f);
      exp_q.push_back(e);
      for (int b = 0; b < n; b++) begin
        for (int s = 0; s < ns; s++) begin
          e = '0;
          e.busy     = 1'b1;
          e.tx_valid = 1'b1;
          e.hop_clk  = (s < ns / 2);
          e.bit_idx  = BCW'(b);
          e.rep_cnt  = NRW'(f);
          e.ph_inc   = c.bits[b] ? c.ph1 : c.ph0;
          exp_q.push_back(e);
        end
      end
    end
    if (c.nrep != 0) begin
      e = '0; e.done = 1'b1; e.rep_cnt = NRW'(c.nrep);
      exp_q.push_back(e);
    end
  endtask

  task automatic apply(input cfg_t c);
    tx_bits  = c.bits;
    ntx_bits = (BCW+1)'(c.ntx);
    nsig     = NSW'(c.nsig);
    nrep     = NRW'(c.nrep);
    ph_inc0  = c.ph0;
    ph_inc1  = c.ph1;
  endtask

  // Start a frame, then compare every cycle; inputs are scrambled and start
  // is toggled while busy, none of which may disturb the latched frame.
  task automatic run(input cfg_t c, input int abort_at, input string tag);
    obs_t e, idle;
    int   hold, len, qn;
    build(c);
    hold = model_rep;
    if (exp_q.size() > 0) hold = int'(exp_q[exp_q.size()-1].rep_cnt);
    if (abort_at >= 0 && abort_at < exp_q.size()) begin
      hold = int'(exp_q[abort_at].rep_cnt);
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    end
    idle = '0; idle.rep_cnt = NRW'(hold);
    qn  = exp_q.size();
    len = qn + 3;
    cnt_busy = 0; cnt_hr = 0; cnt_txv = 0; cnt_done = 0;
    @(negedge clk);
    apply(c);
    start = 1'b1;
    abort = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      e = (i < qn) ? exp_q[i] : idle;
      check_obs($sformatf("%s cyc%0d", tag, i), observe(), e);
      if (busy)     cnt_busy++;
      if (hop_rst)  cnt_hr++;
      if (tx_valid) cnt_txv++;
      if (done)     cnt_done++;
      tx_bits  = {$urandom, $urandom, $urandom, $urandom};
      ntx_bits = (BCW+1)'($urandom);
      nsig     = NSW'($urandom);
      nrep     = NRW'($urandom);
      ph_inc0  = PW'($urandom);
      ph_inc1  = PW'($urandom);
      start    = (i < qn && e.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort    = (i == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    model_rep = hold;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c;
    obs_t idle;
    int   ab, n;

    vt[0] = '{c: mk(128'h0A, 4, 4, 1, 24'h001000, 24'h002000), abort_at: -1,
              e_busy: 17, e_hr: 1, e_txv: 16, e_done: 1, e_rep: 1};
    vt[1] = '{c: mk(128'h0A, 4, 4, 3, 24'h001000, 24'h002000), abort_at: -1,
              e_busy: 51, e_hr: 3, e_txv: 48, e_done: 1, e_rep: 3};
    vt[2] = '{c: mk(128'h05, 3, 1, 1, 24'h111111, 24'h222222), abort_at: -1,
              e_busy: 7, e_hr: 1, e_txv: 6, e_done: 1, e_rep: 1};
    vt[3] = '{c: mk(128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3, 200, 2, 1, 24'h0ABCDE, 24'h543210),
              abort_at: -1, e_busy: 257, e_hr: 1, e_txv: 256, e_done: 1, e_rep: 1};
    vt[4] = '{c: mk(128'hFF, 0, 4, 1, 24'h000001, 24'h000002), abort_at: -1,
              e_busy: 0, e_hr: 0, e_txv: 0, e_done: 0, e_rep: 1};
    vt[5] = '{c: mk(128'h01, 1, 3, 2, 24'h00AAAA, 24'h005555), abort_at: -1,
              e_busy: 8, e_hr: 2, e_txv: 6, e_done: 1, e_rep: 2};
    vt[6] = '{c: mk(128'h0A, 4, 4, 1, 24'h001000, 24'h002000), abort_at: 6,
              e_busy: 7, e_hr: 1, e_txv: 6, e_done: 0, e_rep: 0};
    vt[7] = '{c: mk(128'h02, 2, 2, 0, 24'h003000, 24'h004000), abort_at: 17,
              e_busy: 18, e_hr: 4, e_txv: 14, e_done: 0, e_rep: 3};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    tx_bits = '0; ntx_bits = '0; nsig = '0; nrep = '0; ph_inc0 = '0; ph_inc1 = '0;
    repeat (2) @(negedge clk);
    check_obs("reset_hold", observe(), '0);
    reset = 1'b0;
    @(negedge clk);
    check_obs("reset_release", observe(), '0);

    // Table-driven frames with hand-derived cycle counts.
    for (int v = 0; v < 8; v++) begin
      run(vt[v].c, vt[v].abort_at, $sformatf("vec%0d", v));
      check_int($sformatf("vec%0d busy_cycles", v), cnt_busy, vt[v].e_busy);
      check_int($sformatf("vec%0d hop_rst_pulses", v), cnt_hr, vt[v].e_hr);
      check_int($sformatf("vec%0d tx_valid_cycles", v), cnt_txv, vt[v].e_txv);
      check_int($sformatf("vec%0d done_pulses", v), cnt_done, vt[v].e_done);
      check_int($sformatf("vec%0d final_rep_cnt", v), int'(rep_cnt), vt[v].e_rep);
    end

    // start together with abort in IDLE must not begin a frame.
    @(negedge clk);
    apply(vt[0].c);
    start = 1'b1;
    abort = 1'b1;
    idle = '0; idle.rep_cnt = NRW'(model_rep);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_obs($sformatf("start_abort cyc%0d", i), observe(), idle);
    end

    // Reset asserted while bit 5 is on air, then a clean frame afterwards.
    c = mk(128'hA5, 8, 4, 1, 24'h00F00F, 24'h0F00F0);
    @(negedge clk);
    apply(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    check_int("pre_reset bit_idx", int'(bit_idx), 5);
    #1 reset = 1'b1;
    #1 check_obs("async_reset outputs", observe(), '0);
    @(negedge clk);
    check_obs("reset_held outputs", observe(), '0);
    reset = 1'b0;
    model_rep = 0;
    run(c, -1, "post_reset");
    check_int("post_reset done_pulses", cnt_done, 1);

    // Randomized frames, some aborted at a random cycle.
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 48);
      c = mk({$urandom, $urandom, $urandom, $urandom}, n, $urandom_range(0, 6),
             $urandom_range(1, 3), PW'($urandom), PW'($urandom));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + n * 6) : -1;
      run(c, ab, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
